// File: rtl/conv_rs_stream_core_pkg.sv
// Shared constants, state encoding and column types for the row-stationary conv core.
package conv_rs_stream_core_pkg;

    localparam int conv_dw    = 8;
    localparam int conv_k     = 3;
    localparam int conv_rows  = 4;
    localparam int conv_img_w = 8;

    // Two DW-bit operands give a 2*DW-bit product; K*K of them add log2 bits of growth.
    function automatic int conv_acc_w(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM
    } conv_state_t;

    typedef logic signed [conv_dw-1:0]       conv_px_t;
    typedef logic [conv_k*conv_dw-1:0]       conv_wcol_t;
    typedef logic [conv_rows*conv_dw-1:0]    conv_pcol_t;

endpackage

// File: rtl/conv_window_mac.sv
// Combinational KxK signed dot product: one output-row sum of the convolution window.
module conv_window_mac
    import conv_rs_stream_core_pkg::*;
#(
    parameter int DW    = conv_dw,
    parameter int K     = conv_k,
    parameter int ACC_W = conv_acc_w(conv_dw, conv_k)
) (
    input  logic [K*K*DW-1:0]       w_i,
    input  logic [K*K*DW-1:0]       px_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc;

    // Element i is kernel row i/K, column i%K in both operand vectors.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K*K; i++) begin
            prod = (2*DW)'($signed(w_i[i*DW +: DW])) * (2*DW)'($signed(px_i[i*DW +: DW]));
            acc  = acc + ACC_W'(prod);
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/conv_rs_stream_core.sv
// Row-stationary KxK convolution over a ROWS-high image strip, one column per beat.
// Build option: define CONV_RELU_EN to clamp negative output sums to zero.
module conv_rs_stream_core
    import conv_rs_stream_core_pkg::*;
#(
    parameter int  DW       = conv_dw,
    parameter int  K        = conv_k,
    parameter int  ROWS     = conv_rows,
    parameter int  IMG_W    = conv_img_w,
    localparam int OUT_ROWS = ROWS - K + 1,
    localparam int ACC_W    = conv_acc_w(DW, K)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_start,
    input  logic                      i_w_valid,
    input  logic [K*DW-1:0]           i_w_col,
    output logic                      o_w_ready,
    input  logic                      i_valid,
    input  logic [ROWS*DW-1:0]        i_col,
    output logic                      o_ready,
    output logic                      o_valid,
    output logic [OUT_ROWS*ACC_W-1:0] o_sum,
    input  logic                      i_out_ready,
    output logic                      o_done,
    output logic                      o_busy
);

    localparam int WCW = (K > 1) ? $clog2(K) : 1;
    localparam int CW  = $clog2(IMG_W + 1);

    localparam logic [WCW-1:0] W_LAST    = WCW'(K - 1);
    localparam logic [CW-1:0]  FIRST_OUT = CW'(K - 1);
    localparam logic [CW-1:0]  LAST_COL  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]  ALL_IN    = CW'(IMG_W);

    conv_state_t               state_q;
    logic [WCW-1:0]            wcnt_q;
    logic [CW-1:0]             ccnt_q;
    logic [K*K*DW-1:0]         w_q;
    logic [DW-1:0]             win_q [ROWS][K];
    logic [DW-1:0]             win_d [ROWS][K];
    logic                      o_valid_q;
    logic                      o_done_q;
    logic                      o_busy_q;
    logic                      o_w_ready_q;
    logic                      last_q;
    logic [OUT_ROWS*ACC_W-1:0] o_sum_q;
    logic [OUT_ROWS*ACC_W-1:0] sum_d;
    logic                      pxAccept;
    logic                      outAccept;

    // Once every strip column is in, stop accepting until the job wraps up.
    assign outAccept = o_valid_q && i_out_ready;
    assign o_ready   = (state_q == STREAM) && (ccnt_q != ALL_IN) && (!o_valid_q || i_out_ready);
    assign pxAccept  = i_valid && o_ready;

    // Window as it looks after the incoming column shifts in, so the sum registers on the accepting edge.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < K-1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][K-1] = i_col[r*DW +: DW];
        end
    end

    for (genvar j = 0; j < OUT_ROWS; j++) begin : g_row
        logic [K*K*DW-1:0]       px;
        logic signed [ACC_W-1:0] raw;

        for (genvar r = 0; r < K; r++) begin : g_r
            for (genvar c = 0; c < K; c++) begin : g_c
                assign px[(r*K+c)*DW +: DW] = win_d[j+r][c];
            end
        end

        conv_window_mac #(
            .DW    (DW),
            .K     (K),
            .ACC_W (ACC_W)
        ) u_mac (
            .w_i   (w_q),
            .px_i  (px),
            .sum_o (raw)
        );

`ifdef CONV_RELU_EN
        assign sum_d[j*ACC_W +: ACC_W] = raw[ACC_W-1] ? '0 : raw;
`else
        assign sum_d[j*ACC_W +: ACC_W] = raw;
`endif
    end

    // Control FSM plus weight, window and output registers; a new result wins over an output accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            w_q         <= '0;
            o_valid_q   <= 1'b0;
            o_done_q    <= 1'b0;
            o_busy_q    <= 1'b0;
            o_w_ready_q <= 1'b0;
            last_q      <= 1'b0;
            o_sum_q     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            o_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q     <= LOAD_W;
                        wcnt_q      <= '0;
                        o_w_ready_q <= 1'b1;
                        o_busy_q    <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (i_w_valid) begin
                        for (int r = 0; r < K; r++) begin
                            w_q[(r*K + int'(wcnt_q))*DW +: DW] <= i_w_col[r*DW +: DW];
                        end
                        wcnt_q <= wcnt_q + 1'b1;
                        if (wcnt_q == W_LAST) begin
                            state_q     <= STREAM;
                            o_w_ready_q <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (pxAccept) begin
                        win_q  <= win_d;
                        ccnt_q <= ccnt_q + 1'b1;
                    end
                    if (pxAccept && (ccnt_q >= FIRST_OUT)) begin
                        o_valid_q <= 1'b1;
                        o_sum_q   <= sum_d;
                        last_q    <= (ccnt_q == LAST_COL);
                    end else if (outAccept) begin
                        o_valid_q <= 1'b0;
                        if (last_q) begin
                            state_q  <= IDLE;
                            o_busy_q <= 1'b0;
                            o_done_q <= 1'b1;
                            ccnt_q   <= '0;
                            last_q   <= 1'b0;
                            for (int r = 0; r < ROWS; r++) begin
                                for (int c = 0; c < K; c++) begin
                                    win_q[r][c] <= '0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_w_ready = o_w_ready_q;
    assign o_valid   = o_valid_q;
    assign o_sum     = o_sum_q;
    assign o_done    = o_done_q;
    assign o_busy    = o_busy_q;

endmodule

// File: tb/tb_conv_rs_stream_core.sv
// Self-checking bench for conv_rs_stream_core: default geometry with a 4-column strip,
// plus a K=2 / ROWS=3 / IMG_W=5 instance. Honours CONV_RELU_EN in its reference model.
`timescale 1ns/1ps
module tb_conv_rs_stream_core;

    localparam int DW       = 8;
    localparam int K        = 3;
    localparam int ROWS     = 4;
    localparam int IMG_W    = 4;
    localparam int OUT_ROWS = 2;
    localparam int ACC_W    = 20;
    localparam int NPOS     = IMG_W - K + 1;

    localparam int K2     = 2;
    localparam int ROWS2  = 3;
    localparam int IMG_W2 = 5;
    localparam int ACC_W2 = 18;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      i_start, i_w_valid, i_valid, i_out_ready;
    logic [K*DW-1:0]           i_w_col;
    logic [ROWS*DW-1:0]        i_col;
    logic                      o_w_ready, o_ready, o_valid, o_done, o_busy;
    logic [OUT_ROWS*ACC_W-1:0] o_sum;

    logic                      s_start, s_w_valid, s_valid, s_out_ready;
    logic [K2*DW-1:0]          s_w_col;
    logic [ROWS2*DW-1:0]       s_col;
    logic                      s_w_ready, s_ready, s_o_valid, s_done, s_busy;
    logic [2*ACC_W2-1:0]       s_sum;

    int checks   = 0;
    int failures = 0;

    int jobW  [K][K];
    int jobPx [IMG_W][ROWS];
    int expQ  [$];

    typedef struct packed {
        logic [8:0][7:0] w;
        logic [3:0][7:0] col;
        int              e0;
        int              e1;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    conv_rs_stream_core #(
        .DW(DW), .K(K), .ROWS(ROWS), .IMG_W(IMG_W)
    ) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start),
        .i_w_valid(i_w_valid), .i_w_col(i_w_col), .o_w_ready(o_w_ready),
        .i_valid(i_valid), .i_col(i_col), .o_ready(o_ready),
        .o_valid(o_valid), .o_sum(o_sum), .i_out_ready(i_out_ready),
        .o_done(o_done), .o_busy(o_busy)
    );

    conv_rs_stream_core #(
        .DW(DW), .K(K2), .ROWS(ROWS2), .IMG_W(IMG_W2)
    ) dut_sweep (
        .clk(clk), .rstn(rstn), .i_start(s_start),
        .i_w_valid(s_w_valid), .i_w_col(s_w_col), .o_w_ready(s_w_ready),
        .i_valid(s_valid), .i_col(s_col), .o_ready(s_ready),
        .o_valid(s_o_valid), .o_sum(s_sum), .i_out_ready(s_out_ready),
        .o_done(s_done), .o_busy(s_busy)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int relu(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int sumSlice(input int j);
        logic signed [ACC_W-1:0] v;
        v = o_sum[j*ACC_W +: ACC_W];
        return int'(v);
    endfunction

    // Reference: plain 2-D correlation of the kernel over the strip, position-major.
    task automatic buildModel();
        int s;
        expQ.delete();
        for (int p = 0; p < NPOS; p++) begin
            for (int j = 0; j < OUT_ROWS; j++) begin
                s = 0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        s += jobW[r][c] * jobPx[p+c][j+r];
                expQ.push_back(relu(s));
            end
        end
    endtask

    task automatic applyStimulus(input bit junk);
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        checkOutput("w_ready_load", o_w_ready, 1);
        for (int c = 0; c < K; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                i_w_valid = 1'b0;
                i_valid   = junk;
                i_col     = (ROWS*DW)'($urandom);
                @(posedge clk); #1;
            end
            i_w_valid = 1'b1;
            for (int r = 0; r < K; r++) i_w_col[r*DW +: DW] = jobW[r][c][DW-1:0];
            i_valid = junk;
            i_col   = (ROWS*DW)'($urandom);
            #1;
            checkOutput("ready_in_load", o_ready, 0);
            @(posedge clk); #1;
        end
        i_w_valid = 1'b0;
        i_valid   = 1'b0;
        checkOutput("w_ready_stream", o_w_ready, 0);
    endtask

    // readyMode: 0 always ready, 1 random, 2 stall the first output for 3 cycles.
    task automatic runJob(input int readyMode, input int validMode);
        int  outIdx = 0;
        int  colIdx = 0;
        int  cyc = 0;
        int  stallLeft = 3;
        int  produced, ci;
        bit  expValid;
        bit  expDone = 1'b0;
        while (cyc < 400) begin
            ci = (colIdx < IMG_W) ? colIdx : IMG_W - 1;
            i_valid = (colIdx < IMG_W) && (validMode == 0 || $urandom_range(0, 2) != 0);
            for (int r = 0; r < ROWS; r++) i_col[r*DW +: DW] = jobPx[ci][r][DW-1:0];
            i_w_valid = 1'($urandom_range(0, 1));
            i_w_col   = (K*DW)'($urandom);
            i_start   = (outIdx < NPOS) ? 1'($urandom_range(0, 1)) : 1'b0;
            produced  = (colIdx >= K - 1) ? colIdx - K + 1 : 0;
            expValid  = produced > outIdx;
            case (readyMode)
                0: i_out_ready = 1'b1;
                1: i_out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (expValid && stallLeft > 0) begin
                        i_out_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        i_out_ready = 1'b1;
                    end
                end
            endcase
            #1;
            checkOutput("o_valid", o_valid, expValid);
            checkOutput("o_done", o_done, expDone);
            if (expDone) break;
            checkOutput("o_busy", o_busy, 1);
            if (colIdx < IMG_W) checkOutput("o_ready", o_ready, !expValid || i_out_ready);
            if (o_valid && outIdx < NPOS) begin
                for (int j = 0; j < OUT_ROWS; j++)
                    checkOutput("o_sum", sumSlice(j), expQ[outIdx*OUT_ROWS + j]);
                if (i_out_ready) begin
                    outIdx++;
                    if (outIdx == NPOS) expDone = 1'b1;
                end
            end
            if (i_valid && o_ready) colIdx++;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) checkOutput("job_timeout", 1, 0);
        i_valid   = 1'b0;
        i_start   = 1'b0;
        i_w_valid = 1'b0;
        checkOutput("busy_after_done", o_busy, 0);
    endtask

    task automatic loadVector(input int v);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                jobW[r][c] = int'($signed(tbl[v].w[r*K + c]));
        for (int c = 0; c < IMG_W; c++)
            for (int r = 0; r < ROWS; r++)
                jobPx[c][r] = int'($signed(tbl[v].col[c]));
        expQ.delete();
        for (int j = 0; j < OUT_ROWS; j++) expQ.push_back(relu(tbl[v].e0));
        for (int j = 0; j < OUT_ROWS; j++) expQ.push_back(relu(tbl[v].e1));
    endtask

    task automatic runSweep();
        logic [7:0]              b;
        logic signed [ACC_W2-1:0] v;
        int outIdx = 0;
        int col = 0;
        int cyc = 0;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start   = 1'b0;
        s_w_valid = 1'b1;
        s_w_col   = {8'd1, 8'd1};
        repeat (K2) begin
            @(posedge clk); #1;
        end
        s_w_valid   = 1'b0;
        s_out_ready = 1'b1;
        while (cyc < 100) begin
            b       = 8'(col + 1);
            s_valid = col < IMG_W2;
            s_col   = {b, b, b};
            #1;
            if (s_done) break;
            if (s_o_valid) begin
                for (int j = 0; j < 2; j++) begin
                    v = s_sum[j*ACC_W2 +: ACC_W2];
                    checkOutput("sweep_sum", int'(v), relu(4*outIdx + 6));
                end
                outIdx++;
            end
            if (s_valid && s_ready) col++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checkOutput("sweep_outputs", outIdx, IMG_W2 - K2 + 1);
        checkOutput("sweep_done", s_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = {{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                  {8'd4, 8'd3, 8'd2, 8'd1}, 32'sd96, 32'sd141};
        tbl[1] = {{9{8'hFF}}, {4{8'd1}}, -32'sd9, -32'sd9};
        tbl[2] = {{9{8'h80}}, {4{8'h80}}, 32'sd147456, 32'sd147456};
        tbl[3] = {{9{8'h7F}}, {4{8'h80}}, -32'sd146304, -32'sd146304};
        tbl[4] = {{9{8'd1}}, {8'd10, 8'hFB, 8'd5, 8'd0}, 32'sd0, 32'sd30};

        rstn = 1'b0;
        {i_start, i_w_valid, i_valid, i_out_ready} = '0;
        i_w_col = '0;
        i_col   = '0;
        {s_start, s_w_valid, s_valid, s_out_ready} = '0;
        s_w_col = '0;
        s_col   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_o_valid", o_valid, 0);
        checkOutput("rst_o_done", o_done, 0);
        checkOutput("rst_o_busy", o_busy, 0);
        checkOutput("rst_o_w_ready", o_w_ready, 0);
        checkOutput("rst_o_ready", o_ready, 0);
        checkOutput("rst_o_sum", o_sum, 0);
        rstn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            loadVector(v);
            applyStimulus(v % 2 == 1);
            runJob(v % 2, v % 2);
        end

        $display("[TB] backpressure on first output");
        loadVector(0);
        applyStimulus(1'b0);
        runJob(2, 0);

        $display("[TB] reset in the middle of a job");
        loadVector(0);
        applyStimulus(1'b0);
        i_out_ready = 1'b1;
        i_valid     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < ROWS; r++) i_col[r*DW +: DW] = jobPx[c][r][DW-1:0];
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        rstn    = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        checkOutput("midrst_busy", o_busy, 0);
        checkOutput("midrst_valid", o_valid, 0);
        checkOutput("midrst_w_ready", o_w_ready, 0);
        for (int n = 0; n < 3; n++) begin
            i_valid = 1'b1;
            checkOutput("midrst_done", o_done, 0);
            checkOutput("midrst_ready", o_ready, 0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        loadVector(0);
        applyStimulus(1'b1);
        runJob(0, 0);

        $display("[TB] randomized jobs");
        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    jobW[r][c] = int'($urandom_range(0, 255)) - 128;
            for (int c = 0; c < IMG_W; c++)
                for (int r = 0; r < ROWS; r++)
                    jobPx[c][r] = int'($urandom_range(0, 255)) - 128;
            buildModel();
            applyStimulus(1'b1);
            runJob((n % 3 == 0) ? 0 : 1, n % 2);
        end

        $display("[TB] K=2 ROWS=3 IMG_W=5 instance");
        runSweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_rs_stream_core.md
Name: conv_rs_stream_core

Overview:
Parametrised row-stationary convolution core. It is the generalised successor of the fixed 4-row / 3x3 conv core.
- Loads a KxK weight kernel column by column, then streams an image strip of ROWS rows, one column per beat.
- Emits ROWS-K+1 output-row sums per sliding-window position, with valid/ready backpressure and a done pulse.
- Sits between the feature-map line buffer and the accumulation/requant stage of the conv stem.

Parameters:
DW, 8, signed pixel/weight width (two's complement)
K, 3, kernel size (KxK), >=2
ROWS, 4, input rows per strip, >=K
IMG_W, 8, columns per strip, >=K
OUT_ROWS (localparam), ROWS-K+1, output rows per window
ACC_W (localparam), 2*DW+$clog2(K*K), signed accumulator width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_start  in  1  begin a job; sampled only in IDLE
i_w_valid  in  1  weight column valid
i_w_col  in  K*DW  weight column; slice r = kernel row r
o_w_ready  out  1  high in LOAD_W
i_valid  in  1  pixel column valid
i_col  in  ROWS*DW  pixel column; slice r = strip row r
o_ready  out  1  pixel column accepted when i_valid&&o_ready
o_valid  out  1  output sums valid
o_sum  out  OUT_ROWS*ACC_W  slice j = output row j
i_out_ready  in  1  downstream accepts o_sum
o_done  out  1  one-cycle pulse, job complete
o_busy  out  1  state != IDLE

Behaviour:
Interface:
- One clock, clk. Reset rstn is synchronous and active-low; no asynchronous reset.
- Reset (rstn low at a clk edge): state=IDLE; o_valid=0; o_sum=0; o_done=0; o_busy=0; o_w_ready=0; o_ready=0; column counters and window registers cleared; weights cleared.

FSM IDLE -> LOAD_W -> STREAM -> IDLE:
- IDLE: i_start=1 moves to LOAD_W. i_start is ignored in every other state.
- LOAD_W:
  - o_w_ready=1.
  - Each i_w_valid beat stores kernel column wcnt (0..K-1).
  - On the K-th beat, go to STREAM.
  - Pixel inputs are ignored (o_ready=0).
- STREAM:
  - o_ready = !o_valid || i_out_ready (one-deep output skid).
  - Each accepted column shifts into a K-column window register and increments ccnt (0..IMG_W-1).
  - Columns with ccnt<K-1 only fill the window.
  - Column ccnt>=K-1 accepted at edge t gives o_valid=1 from t+1.
  - o_sum[j] = sum over r<K, c<K of w[r][c]*px[j+r][ccnt-K+1+c], signed, full ACC_W precision, no overflow possible.
  - o_valid/o_sum hold stable while i_out_ready=0.
  - o_valid clears on an accept unless a new result is loaded in the same cycle; a simultaneous accept and new column gives back-to-back outputs with no bubble.
- Job end: when the output for ccnt=IMG_W-1 is accepted, o_done=1 for exactly one cycle and the state returns to IDLE. The window and counters are cleared; weights are retained but reloaded on the next job.
- i_w_valid outside LOAD_W and i_valid outside STREAM are ignored.
- Reset mid-job aborts immediately with no o_done; a partial output is discarded.

Optional Feature:
CONV_RELU_EN:
- Defined: each o_sum slice is clamped to 0 when its value is negative (ReLU applied at the output register).
- Undefined: raw signed sums are output.
- Timing and handshake are identical in both builds.

Decomposition:
- Package definition: conv_dw, conv_k, conv_rows, conv_img_w constants; ACC_W helper function; typedef enum logic [1:0] {IDLE, LOAD_W, STREAM} conv_state_t; packed weight/column typedefs.
- Sub-module conv_window_mac: combinational KxK signed dot product (K*K weights, K*K pixels -> ACC_W sum). Instantiated OUT_ROWS times.

Test Plan:
- Basic strip, defaults with IMG_W=4:
  - Stimulus: weight columns (1,4,7), (2,5,8), (3,6,9); pixel columns all-1, all-2, all-3, all-4; i_out_ready=1.
  - Response: first o_valid one cycle after column 3 is accepted, o_sum=(96,96); then (141,141); o_done pulses the cycle after the second accept.
- Backpressure:
  - Stimulus: same job, i_out_ready=0 for 3 cycles at the first output.
  - Response: o_valid=1 and o_sum=(96,96) held stable; o_ready=0; column 4 is not consumed until release; then (141,141).
- Sign/ReLU:
  - Stimulus: all weights -1, all pixels 1.
  - Response: o_sum=-9 per row without CONV_RELU_EN; 0 with it. Max-negative operands (-128 x -128 x 9 = 147456) fit ACC_W=20 without wrap.
- Reset mid-job:
  - Stimulus: rstn low for 1 cycle after 2 pixel columns.
  - Response: next edge shows IDLE, o_busy=0, o_valid=0; no o_done; a new job produces correct results.
- Protocol:
  - Stimulus: i_start during STREAM; i_valid during LOAD_W.
  - Response: both ignored; results unchanged.
- Parameter sweep:
  - Stimulus: K=2, ROWS=3, IMG_W=5, all weights 1, pixel column n all n+1.
  - Response: OUT_ROWS=2; 4 outputs per row: 6, 10, 14, 18.
